// File: rtl/mm_stream_tx.sv
// mm_stream_tx: streams two row-major matrices from element memory into MM with framing and back-pressure
module mm_stream_tx #(
  parameter int DATA_W = 8,
  parameter int DIM_W  = 4,
  parameter int ADDR_W = 14,
  parameter int IDX_W  = 9
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [DIM_W-1:0]  m1_rows_i,
  input  logic [DIM_W-1:0]  m1_cols_i,
  input  logic [DIM_W-1:0]  m2_rows_i,
  input  logic [DIM_W-1:0]  m2_cols_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              busy_i,
  output logic [DATA_W-1:0] in_data_o,
  output logic              col_end_o,
  output logic              row_end_o,
  output logic              data_vld_o,
  output logic              tx_busy_o,
  output logic              done_o,
  output logic              err_o
);
  typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_t;
  state_t state_q, state_d;
  logic [DIM_W-1:0] m1r_q, m1c_q, m2r_q, m2c_q, m1r_d, m1c_d, m2r_d, m2c_d;
  logic [DIM_W-1:0] col_q, row_q, col_d, row_d, cols, rows;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic phase_q, phase_d, ce_q, ce_d, re_q, re_d, vld_q, vld_d, done_q, done_d, err_q, err_d;
  logic ce, re, last, ld, zero;
  assign cols = phase_q ? m2c_q : m1c_q;
  assign rows = phase_q ? m2r_q : m1r_q;
  assign ce = col_q == cols - DIM_W'(1);
  assign re = ce && row_q == rows - DIM_W'(1);
  // counters run one element ahead, so phase has already wrapped back to 0 once matrix 2 ends
  assign last = re_q && !phase_q;
  assign zero = m1_rows_i == '0 || m1_cols_i == '0 || m2_rows_i == '0 || m2_cols_i == '0;
  assign mem_addr_o = base_q + ADDR_W'(ptr_q);
  assign in_data_o = data_q;
  assign col_end_o = ce_q;
  assign row_end_o = re_q;
  assign data_vld_o = vld_q;
  assign tx_busy_o = state_q != IDLE;
  assign done_o = done_q;
  assign err_o = err_q;
  // next-state, counter advance and output register loading
  always_comb begin
    state_d = state_q;
    {m1r_d, m1c_d, m2r_d, m2c_d} = {m1r_q, m1c_q, m2r_q, m2c_q};
    base_d = base_q;
    ptr_d = ptr_q;
    col_d = col_q;
    row_d = row_q;
    phase_d = phase_q;
    data_d = data_q;
    ce_d = ce_q;
    re_d = re_q;
    vld_d = vld_q;
    done_d = 1'b0;
    err_d = 1'b0;
    ld = 1'b0;
    case (state_q)
      IDLE: if (start_i) begin
        if (zero) err_d = 1'b1;
        else begin
          {m1r_d, m1c_d, m2r_d, m2c_d} = {m1_rows_i, m1_cols_i, m2_rows_i, m2_cols_i};
          base_d = base_addr_i;
          ptr_d = '0;
          col_d = '0;
          row_d = '0;
          phase_d = 1'b0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        ld = 1'b1;
        state_d = SEND;
      end
      SEND: if (!busy_i) begin
        if (last) begin
          {vld_d, ce_d, re_d} = 3'b000;
          done_d = 1'b1;
          state_d = DONE;
        end else ld = 1'b1;
      end
      DONE: state_d = IDLE;
    endcase
    if (ld) begin
      data_d = mem_rdata_i;
      ce_d = ce;
      re_d = re;
      vld_d = 1'b1;
      ptr_d = ptr_q + IDX_W'(1);
      col_d = ce ? '0 : col_q + DIM_W'(1);
      row_d = re ? '0 : ce ? row_q + DIM_W'(1) : row_q;
      phase_d = phase_q ^ re;
    end
  end
  // state and datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      {m1r_q, m1c_q, m2r_q, m2c_q} <= '0;
      base_q <= '0;
      ptr_q <= '0;
      col_q <= '0;
      row_q <= '0;
      phase_q <= 1'b0;
      data_q <= '0;
      {ce_q, re_q, vld_q, done_q, err_q} <= '0;
    end else begin
      state_q <= state_d;
      {m1r_q, m1c_q, m2r_q, m2c_q} <= {m1r_d, m1c_d, m2r_d, m2c_d};
      base_q <= base_d;
      ptr_q <= ptr_d;
      col_q <= col_d;
      row_q <= row_d;
      phase_q <= phase_d;
      data_q <= data_d;
      {ce_q, re_q, vld_q, done_q, err_q} <= {ce_d, re_d, vld_d, done_d, err_d};
    end
  end
endmodule

// File: tb/tb_mm_stream_tx.sv
// tb_mm_stream_tx: table-driven and randomized checks of mm_stream_tx against a row-major stream model
module tb_mm_stream_tx;
  logic clk_i = 1'b0, rst_ni = 1'b0, start_i = 1'b0, busy_i = 1'b0;
  logic [3:0] m1_rows_i = '0, m1_cols_i = '0, m2_rows_i = '0, m2_cols_i = '0;
  logic [13:0] base_addr_i = '0, mem_addr_o;
  logic [7:0] mem_rdata_i, in_data_o;
  logic col_end_o, row_end_o, data_vld_o, tx_busy_o, done_o, err_o;
  logic [7:0] mem [0:16383];
  int vec = 0, errs = 0;

  typedef struct {
    int m1r, m1c, m2r, m2c, base, mode, exp_err, exp_n;
  } vec_t;
  typedef struct {
    logic [7:0] d;
    logic ce, re;
  } el_t;

  mm_stream_tx dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i),
    .m1_rows_i(m1_rows_i), .m1_cols_i(m1_cols_i), .m2_rows_i(m2_rows_i), .m2_cols_i(m2_cols_i),
    .base_addr_i(base_addr_i), .mem_addr_o(mem_addr_o), .mem_rdata_i(mem_rdata_i), .busy_i(busy_i),
    .in_data_o(in_data_o), .col_end_o(col_end_o), .row_end_o(row_end_o), .data_vld_o(data_vld_o),
    .tx_busy_o(tx_busy_o), .done_o(done_o), .err_o(err_o)
  );

  assign mem_rdata_i = mem[mem_addr_o];
  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_start(input int m1r, m1c, m2r, m2c, base);
    @(negedge clk_i);
    m1_rows_i = 4'(m1r);
    m1_cols_i = 4'(m1c);
    m2_rows_i = 4'(m2r);
    m2_cols_i = 4'(m2c);
    base_addr_i = 14'(base);
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  // mode 0: busy low, 1: random busy, 2: busy held 3 edges on element stall_k
  task automatic run(input int m1r, m1c, m2r, m2c, base, mode, stall_k, poke,
                     output int cyc, output int hold);
    el_t q[$];
    el_t e;
    int dims[4];
    int k, stalls, n;
    logic [13:0] a;
    dims = '{m1r, m1c, m2r, m2c};
    a = 14'(base);
    for (int m = 0; m < 2; m++)
      for (int r = 0; r < dims[2*m]; r++)
        for (int c = 0; c < dims[2*m+1]; c++) begin
          e.d = mem[a];
          e.ce = c == dims[2*m+1] - 1;
          e.re = e.ce && r == dims[2*m] - 1;
          q.push_back(e);
          a++;
        end
    n = q.size();
    drive_start(m1r, m1c, m2r, m2c, base);
    chk("load_tx_busy", 32'(tx_busy_o), 1);
    chk("load_vld", 32'(data_vld_o), 0);
    k = 0;
    cyc = 0;
    hold = 0;
    stalls = 0;
    while (k < n && cyc < 2000) begin
      @(negedge clk_i);
      cyc++;
      if (poke != 0 && cyc == 2) begin
        start_i = 1'b1;
        m2_cols_i = 4'd0;
        m1_rows_i = 4'(15);
      end else start_i = 1'b0;
      if (data_vld_o !== 1'b1 || in_data_o !== q[k].d || col_end_o !== q[k].ce ||
          row_end_o !== q[k].re || done_o !== 1'b0 || err_o !== 1'b0) begin
        chk("elem_vld", 32'(data_vld_o), 1);
        chk("elem_data", 32'(in_data_o), 32'(q[k].d));
        chk("elem_flags", {30'd0, col_end_o, row_end_o}, {30'd0, q[k].ce, q[k].re});
        chk("elem_done_err", {30'd0, done_o, err_o}, 0);
      end else vec++;
      if (k == stall_k) hold++;
      busy_i = mode == 1 ? $urandom_range(0, 3) == 0 :
               mode == 2 ? k == stall_k && stalls < 3 : 1'b0;
      if (mode == 2 && busy_i) stalls++;
      if (!busy_i) k++;
    end
    start_i = 1'b0;
    busy_i = 1'b0;
    chk("elem_count", 32'(k), 32'(n));
    @(negedge clk_i);
    chk("done_pulse", 32'(done_o), 1);
    chk("done_vld_low", {30'd0, data_vld_o, col_end_o | row_end_o}, 0);
    @(negedge clk_i);
    chk("done_clear", {30'd0, done_o, tx_busy_o}, 0);
  endtask

  task automatic run_err(input int m1r, m1c, m2r, m2c);
    drive_start(m1r, m1c, m2r, m2c, 0);
    chk("err_pulse", 32'(err_o), 1);
    chk("err_tx_busy", 32'(tx_busy_o), 0);
    @(negedge clk_i);
    chk("err_clear", 32'(err_o), 0);
    repeat (3) @(negedge clk_i);
    chk("err_idle", {30'd0, data_vld_o, tx_busy_o}, 0);
  endtask

  initial begin
    vec_t tbl[$];
    int cyc, hold;
    for (int i = 0; i < 16384; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 12; i++) mem[i] = 8'(i + 1);
    mem[200] = 8'hAA;
    mem[201] = 8'h55;
    tbl = '{
      '{2, 3, 3, 2, 0, 0, 0, 12},
      '{1, 1, 1, 1, 200, 0, 0, 2},
      '{2, 3, 2, 2, 300, 0, 0, 10},
      '{1, 15, 15, 1, 400, 0, 0, 30},
      '{4, 1, 1, 4, 500, 0, 0, 8},
      '{15, 15, 15, 15, 1000, 0, 0, 450},
      '{3, 5, 5, 3, 2000, 1, 0, 30},
      '{7, 2, 9, 6, 3000, 1, 0, 68},
      '{2, 3, 3, 0, 0, 0, 1, 0},
      '{0, 3, 3, 2, 0, 0, 1, 0}
    };
    #12;
    chk("rst_outputs", {24'd0, in_data_o}, 0);
    chk("rst_flags", {25'd0, col_end_o, row_end_o, data_vld_o, tx_busy_o, done_o, err_o}, 0);
    chk("rst_addr", 32'(mem_addr_o), 0);
    rst_ni = 1'b1;
    foreach (tbl[i]) begin
      if (tbl[i].exp_err != 0) run_err(tbl[i].m1r, tbl[i].m1c, tbl[i].m2r, tbl[i].m2c);
      else begin
        run(tbl[i].m1r, tbl[i].m1c, tbl[i].m2r, tbl[i].m2c, tbl[i].base, tbl[i].mode, -1, 0, cyc, hold);
        if (tbl[i].mode == 0) chk("throughput", 32'(cyc), 32'(tbl[i].exp_n));
      end
    end
    run(2, 3, 3, 2, 0, 2, 3, 0, cyc, hold);
    chk("stall_hold", 32'(hold), 4);
    chk("stall_cycles", 32'(cyc), 15);
    run(2, 3, 3, 2, 0, 0, -1, 1, cyc, hold);
    chk("ignored_start_cycles", 32'(cyc), 12);
    for (int t = 0; t < 6; t++)
      run($urandom_range(1, 6), $urandom_range(1, 6), $urandom_range(1, 6), $urandom_range(1, 6),
          $urandom_range(0, 8000), 1, -1, 0, cyc, hold);
    drive_start(2, 3, 3, 2, 0);
    repeat (5) @(negedge clk_i);
    chk("pre_rst_elem5", 32'(in_data_o), 5);
    #2 rst_ni = 1'b0;
    #1;
    chk("async_rst_data", {24'd0, in_data_o}, 0);
    chk("async_rst_flags", {26'd0, col_end_o, row_end_o, data_vld_o, tx_busy_o, done_o, err_o}, 0);
    chk("async_rst_addr", 32'(mem_addr_o), 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (3) begin
      @(negedge clk_i);
      chk("no_done_after_rst", {30'd0, done_o, tx_busy_o}, 0);
    end
    run(2, 3, 3, 2, 0, 0, -1, 0, cyc, hold);
    chk("restart_cycles", 32'(cyc), 12);
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule

// File: doc/mm_stream_tx.md
# mm_stream_tx

Matrix stream transmitter that drives the input side of the `MM` matrix-multiply block. Given a shape descriptor and a base address, it reads matrix 1 and then matrix 2 row-major from an asynchronous-read element memory. It presents one element per cycle on `in_data` with `col_end`/`row_end` framing and stalls while `MM` asserts `busy`. It replaces the bench-side driver loop so that `MM` can be fed by on-chip logic.

## Interface
- `DATA_W`, 8: element width, matching the `MM` `in_data` port.
- `DIM_W`, 4: width of each dimension field; legal dimensions are 1..15.
- `ADDR_W`, 14: element memory address width.
- `IDX_W`, 9: element index width; covers up to 2*15*15 = 450 elements.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `m1_rows`, `m1_cols`, `m2_rows`, `m2_cols`  in  DIM_W each  shape fields, latched on accepted `start`.
- `base_addr`  in  ADDR_W  address of element 0 of matrix 1, latched on accepted `start`.
- `mem_addr`  out  ADDR_W  element read address, defined as base_q + rd_ptr.
- `mem_rdata`  in  DATA_W  element at `mem_addr`, valid in the same cycle (combinational read).
- `busy`  in  1  `MM` back-pressure; an element is consumed only at an edge where `busy`==0.
- `in_data`  out  DATA_W  registered element toward `MM`.
- `col_end`  out  1  registered; marks the last element of a row of the current matrix.
- `row_end`  out  1  registered; marks the last element of the current matrix.
- `data_vld`  out  1  registered; `in_data` and the flags are meaningful.
- `tx_busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse after the final element is consumed.
- `err`  out  1  one-cycle pulse when a `start` is rejected.

## Operation
- **Reset:** state goes to IDLE. All registered outputs go to 0: `in_data`, `col_end`, `row_end`, `data_vld`, `done`, `err`, `tx_busy`. `rd_ptr` and base_q also reset to 0, so `mem_addr` = 0.
- **Counters:** `rd_ptr` is the next element to load. `col_cnt` is the column position within the current matrix. `phase` is 0 for matrix 1 and 1 for matrix 2. The total element count is n1 + n2, where n1 = m1_rows*m1_cols and n2 = m2_rows*m2_cols. Flags come from the counters only, with no modulus hardware.
- **IDLE:**
  - `start` with any dimension equal to 0: `err` pulses next cycle; state stays IDLE.
  - Otherwise: latch the shape fields and `base_addr`; clear `rd_ptr`, `col_cnt` and `phase`; go to LOAD.
- **LOAD** (one cycle):
  - Register `in_data` <= `mem_rdata`.
  - `col_end` = (`col_cnt` == cols-1), where cols is the current matrix's column count.
  - `row_end` = (element is the last of the current matrix).
  - Set `data_vld` <= 1; increment `rd_ptr`; go to SEND.
- **SEND:**
  - At an edge with `busy`==1: hold all outputs and `rd_ptr` unchanged.
  - At an edge with `busy`==0, when the presented element is not the last: load the next element from `mem_rdata`, recompute the flags, advance `rd_ptr` and `col_cnt`. `col_cnt` wraps to 0 after cols-1. When `row_end` was set, `phase` toggles and `col_cnt` clears.
  - At an edge with `busy`==0, when the presented element is the last of matrix 2: clear `data_vld`, `col_end` and `row_end`; go to DONE.
- **DONE:** `done`=1 for one cycle; go to IDLE.
- **No shape check:** `m1_cols` != `m2_rows` is transmitted normally. Legality is `MM`'s job (`is_legal`).
- **1-wide rows:** a 1-column matrix asserts `col_end` on every element. A 1x1 matrix asserts `col_end` and `row_end` together.
- **Ignored requests:** `start` outside IDLE is ignored; no `err` is raised.

## Timing
- `start` at edge T0 → LOAD during cycle T0..T1 → element 0 visible after T1 with `data_vld`=1.
- Throughput is 1 element/cycle with `busy` low. Element k+1 appears after the edge that consumed element k.
- With `busy` low throughout, the last element is consumed at edge T1+n1+n2 and `done` is high during the following cycle. `tx_busy` falls with the return to IDLE.
- `mem_addr` must be stable for the whole LOAD/SEND cycle. The memory read path is combinational into the `in_data` register.
- `busy` is sampled only at rising edges. A `busy` change between edges has no effect.
- Asynchronous reset mid-transfer: outputs go to 0 immediately, the transfer is abandoned, and no `done` pulse occurs.

## Test plan
- **2x3 then 3x2, `busy`=0, memory = 1..12:** `in_data` sequence 1..12 on consecutive cycles. `col_end` on elements 3, 6, 8, 10, 12. `row_end` on elements 6 and 12. `done` one cycle after element 12 is consumed.
- **Same shapes, `busy` forced high for 3 cycles while element 4 is presented:** element 4 is held exactly 4 cycles and flags are unchanged. Sequence and total count are unchanged; `done` is delayed by 3 cycles.
- **1x1 then 1x1, memory {0xAA, 0x55}:** both elements carry `col_end`=`row_end`=1. `done` follows element 2.
- **Mismatched 2x3 then 2x2:** all 10 elements are sent with correct framing and no `err`.
- **`start` with `m2_cols`=0:** `err` pulses once, `tx_busy` stays 0, and `data_vld` never rises. A second `start` during an active transfer is ignored.
- **`rst` low while element 5 is presented:** outputs immediately go to 0. After release, a new `start` restarts from `base_addr` with element 0.
